// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce bank: parameter limits,
// default values and the counter-width calculation.
package debounce_pkg;

  // Legal parameter ranges.
  localparam int CHANNELS_MIN = 1;
  localparam int CHANNELS_MAX = 32;
  localparam int DELAY_MIN    = 1;
  localparam int DELAY_MAX    = (1 << 20) - 1;
  localparam int SYNC_MIN     = 2;
  localparam int SYNC_MAX     = 4;

  // Defaults used by the top level.
  localparam int DEFAULT_CHANNELS    = 4;
  localparam int DEFAULT_DELAY       = 20000;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam bit DEFAULT_INIT        = 1'b0;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  // Width of a counter that must hold the values 0..delay.
  function automatic int cnt_width(input int delay);
    return clog2(delay + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: input synchroniser, stability counter, debounced level
// and registered rise/fall pulses. change_next exposes the pulse that will be
// registered on the coming edge so the top can align any_change with it.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DELAY       = DEFAULT_DELAY,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter bit INIT        = DEFAULT_INIT
) (
  input  logic clk,
  input  logic rst_n,        // active-high asynchronous reset despite the name
  input  logic tick,
  input  logic button,
  output logic debounced,
  output logic rise,
  output logic fall,
  output logic change_next
);

  localparam int                 CNT_W    = cnt_width(DELAY);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DELAY - 1);

  if (DELAY < DELAY_MIN || DELAY > DELAY_MAX) begin : g_bad_delay
    $error("debounce_channel: DELAY out of range");
  end
  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("debounce_channel: SYNC_STAGES out of range");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   deb_q, deb_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Next-state logic: shift the synchroniser, qualify the mismatch, accept.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    sync_d = {sync_q[SYNC_STAGES-2:0], button};
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s == deb_q) begin
      // Stable level: drop any partial count, whether or not this is a tick.
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CNT_LAST) begin
        deb_d  = s;
        cnt_d  = '0;
        rise_d = s;
        fall_d = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset loads INIT everywhere so release emits no pulse.
  always_ff @(posedge clk or posedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    if (rst_n) begin
      sync_q <= {SYNC_STAGES{INIT}};
      cnt_q  <= '0;
      deb_q  <= INIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign debounced   = deb_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign change_next = rise_d | fall_d;

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounce channels plus a registered any_change flag
// that rises in the same cycle as the per-channel pulses.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS    = DEFAULT_CHANNELS,
  parameter int DELAY       = DEFAULT_DELAY,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter bit INIT        = DEFAULT_INIT
) (
  input  logic                clk,
  input  logic                rst_n,   // active-high asynchronous reset
  input  logic                tick,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_change
);

  if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
    $error("debounce_bank: CHANNELS out of range");
  end

  logic [CHANNELS-1:0] change_next;
  logic                any_change_q, any_change_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .DELAY       (DELAY),
      .SYNC_STAGES (SYNC_STAGES),
      .INIT        (INIT)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .button      (button[i]),
      .debounced   (debounced[i]),
      .rise        (rise[i]),
      .fall        (fall[i]),
      .change_next (change_next[i])
    );
  end

  // Any channel about to pulse on this edge.
  always_comb begin
    any_change_d = |change_next;
  end

  // Register the flag alongside the channel pulse flops.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) any_change_q <= 1'b0;
    else       any_change_q <= any_change_d;
  end

  assign any_change = any_change_q;

endmodule
